// File: rtl/lif_row_snapshot.sv
// ---------------------------------------------------------------------------
// lif_row_snapshot
//
// Readout stage for one row of lif cells. A snap_req in IDLE freezes the
// 4-bit state of all NCELLS cells into a snapshot register. The frozen
// nibbles are then streamed out, cell 0 first, over a valid/ready handshake.
// While streaming, the number of set state bits (the particle count) is
// accumulated. After the last transfer there is one DONE cycle that
// publishes the total and bumps the frame counter.
//
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   cells_in      concatenated cell states, cell i = cells_in[4i+3:4i]
//   snap_req      capture request, sampled on every rising edge
//   out_data      nibble of the cell currently offered
//   out_valid     out_data is valid (high throughout SEND)
//   out_ready     consumer accepts out_data when high with out_valid
//   out_last      high with out_valid on cell NCELLS-1
//   busy          high in SEND and DONE
//   pop_count     particle total of the last completed snapshot
//   count_valid   one-cycle pulse when pop_count updates (the DONE cycle)
//   snap_dropped  one-cycle pulse after a snap_req seen while busy
//   frames_sent   completed snapshots, wraps 255 -> 0
// ---------------------------------------------------------------------------
module lif_row_snapshot #(
    parameter int NCELLS = 8,
    parameter int CNT_W  = $clog2(4 * NCELLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*NCELLS-1:0]   cells_in,
    input  logic                  snap_req,
    output logic [3:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      pop_count,
    output logic                  count_valid,
    output logic                  snap_dropped,
    output logic [7:0]            frames_sent
);

    localparam int IDX_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4*NCELLS-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      pop_count_q, pop_count_d;
    logic                  count_valid_q, count_valid_d;
    logic                  snap_dropped_q, snap_dropped_d;
    logic [7:0]            frames_q, frames_d;

    // Split the frozen snapshot into per-cell nibbles for indexed readout.
    logic [3:0] cell_nib [NCELLS];

    genvar gi;
    generate
        for (gi = 0; gi < NCELLS; gi++) begin : g_nib
            assign cell_nib[gi] = snap_q[4*gi +: 4];
        end
    endgenerate

    logic [2:0]       nib_pop;
    logic [CNT_W-1:0] acc_sum;
    logic             at_last;

    assign out_data  = cell_nib[idx_q];
    assign at_last   = (idx_q == LAST_IDX);
    assign nib_pop   = {2'b00, out_data[0]} + {2'b00, out_data[1]}
                     + {2'b00, out_data[2]} + {2'b00, out_data[3]};
    // Accumulator including the nibble offered this cycle; used both for the
    // running sum and, on the last transfer, for the published total.
    assign acc_sum   = acc_q + CNT_W'(nib_pop);

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        pop_count_d    = pop_count_q;
        count_valid_d  = 1'b0;
        snap_dropped_d = 1'b0;
        frames_d       = frames_q;

        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    snap_d  = cells_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                snap_dropped_d = snap_req;
                if (out_ready) begin
                    acc_d = acc_sum;
                    if (at_last) begin
                        // Publish on the edge into DONE so the DONE cycle
                        // already shows the final total and frame count.
                        state_d       = S_DONE;
                        pop_count_d   = acc_sum;
                        count_valid_d = 1'b1;
                        frames_d      = frames_q + 8'd1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                snap_dropped_d = snap_req;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            snap_q         <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            pop_count_q    <= '0;
            count_valid_q  <= 1'b0;
            snap_dropped_q <= 1'b0;
            frames_q       <= 8'd0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            pop_count_q    <= pop_count_d;
            count_valid_q  <= count_valid_d;
            snap_dropped_q <= snap_dropped_d;
            frames_q       <= frames_d;
        end
    end

    assign out_valid    = (state_q == S_SEND);
    assign out_last     = (state_q == S_SEND) && at_last;
    assign busy         = (state_q != S_IDLE);
    assign pop_count    = pop_count_q;
    assign count_valid  = count_valid_q;
    assign snap_dropped = snap_dropped_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_lif_row_snapshot.sv
// ---------------------------------------------------------------------------
// tb_lif_row_snapshot
//
// Self-checking bench for lif_row_snapshot (NCELLS=8). Every cycle the DUT
// outputs are compared on the falling edge against a behavioural model that
// keeps the captured word, the position in the frame and the running total
// as plain integers. Directed scenarios are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_lif_row_snapshot;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(4 * N + 1);

    logic              clk;
    logic              rst_n;
    logic [4*N-1:0]    cells_in;
    logic              snap_req;
    logic [3:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic [CNT_W-1:0]  pop_count;
    logic              count_valid;
    logic              snap_dropped;
    logic [7:0]        frames_sent;

    lif_row_snapshot #(.NCELLS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cells_in     (cells_in),
        .snap_req     (snap_req),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .pop_count    (pop_count),
        .count_valid  (count_valid),
        .snap_dropped (snap_dropped),
        .frames_sent  (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = streaming, 2 = done cycle.
    int          m_phase = 0;
    logic [31:0] m_word  = '0;
    int          m_pos   = 0;
    int          m_acc   = 0;
    int          m_pop   = 0;
    bit          m_cv    = 0;
    bit          m_drop  = 0;
    int          m_frames = 0;

    function automatic logic [3:0] m_nib();
        logic [31:0] w;
        w = m_word >> (4 * m_pos);
        return w[3:0];
    endfunction

    // Check the current cycle, apply the next inputs, predict the next edge.
    task automatic step(input logic req, input logic rdy, input logic [31:0] cells, input logic rn);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_phase == 1));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("out_last", 32'(out_last), 32'(m_phase == 1 && m_pos == N - 1));
        if (m_phase == 1) check("out_data", 32'(out_data), 32'(m_nib()));
        check("pop_count", 32'(pop_count), 32'(m_pop));
        check("count_valid", 32'(count_valid), 32'(m_cv));
        check("snap_dropped", 32'(snap_dropped), 32'(m_drop));
        check("frames_sent", 32'(frames_sent), 32'(m_frames));
        if (m_cv)
            $display("frame done: pop_count=%0d frames_sent=%0d", pop_count, frames_sent);

        snap_req  = req;
        out_ready = rdy;
        cells_in  = cells;
        rst_n     = rn;

        if (!rn) begin
            m_phase = 0; m_word = '0; m_pos = 0; m_acc = 0;
            m_pop = 0; m_cv = 0; m_drop = 0; m_frames = 0;
        end else begin
            m_cv   = 0;
            m_drop = (m_phase != 0) && req;
            case (m_phase)
                0: if (req) begin
                    m_word = cells; m_pos = 0; m_acc = 0; m_phase = 1;
                end
                1: if (rdy) begin
                    m_acc += $countones(m_nib());
                    if (m_pos == N - 1) begin
                        m_pop    = m_acc;
                        m_cv     = 1;
                        m_frames = (m_frames + 1) % 256;
                        m_phase  = 2;
                    end else begin
                        m_pos++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    initial begin
        int drops;
        rst_n     = 1'b0;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        cells_in  = '0;
        @(posedge clk);

        // Reset, then idle with no requests.
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 32'h1234_5678, 1);

        // Single frame, consumer always ready.
        step(1, 1, 32'h0000_A5F1, 1);
        for (int i = 0; i < 9; i++) step(0, 1, 32'h0000_A5F1, 1);
        check("A5F1 count_valid", 32'(count_valid), 32'd1);
        check("A5F1 pop_count", 32'(pop_count), 32'd9);
        check("A5F1 frames", 32'(frames_sent), 32'd1);

        // Same capture with stalls; cells_in changes to all-F after capture.
        step(1, 1, 32'h0000_A5F1, 1);
        for (int k = 0; k < 30; k++) step(0, (k % 3) == 0, 32'hFFFF_FFFF, 1);
        check("stall pop_count", 32'(pop_count), 32'd9);
        check("stall frames", 32'(frames_sent), 32'd2);

        // snap_req held high for two full frames.
        drops = 0;
        for (int k = 0; k < 2 * (N + 2); k++) begin
            step(1, 1, 32'h1357_9BDF, 1);
            if (snap_dropped) drops++;
        end
        step(0, 1, 32'h0, 1);
        check("held frames", 32'(frames_sent), 32'd4);
        check("held drops", 32'(drops), 32'(2 * (N + 1) - 1));

        // Reset on the 4th transfer aborts the frame.
        step(1, 1, 32'hFFFF_FFFF, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 32'hFFFF_FFFF, 1);
        step(0, 1, 32'hFFFF_FFFF, 0);
        step(0, 1, 32'hFFFF_FFFF, 1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort frames", 32'(frames_sent), 32'd0);
        check("abort count_valid", 32'(count_valid), 32'd0);

        // 256 back-to-back frames of all-F; frames_sent wraps to 0.
        for (int f = 0; f < 256; f++) begin
            step(1, 1, 32'hFFFF_FFFF, 1);
            for (int k = 0; k < N + 1; k++) step(0, 1, 32'hFFFF_FFFF, 1);
            check("allF pop_count", 32'(pop_count), 32'd32);
        end
        check("wrap frames", 32'(frames_sent), 32'd0);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom, 1);

        step(0, 1, 32'h0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_row_snapshot.md
Name: lif_row_snapshot

Overview:
Downstream readout stage for a row of lif cells. On request it captures the 4-bit state of NCELLS cells in one cycle and streams the frozen states out one nibble per transfer over a valid/ready interface. While streaming it accumulates a particle count, the number of set state bits. It lets the host or scan logic observe the lattice without stalling the cell array.

Parameters:
NCELLS, 8, number of cells captured per snapshot (minimum 2)
CNT_W, $clog2(4*NCELLS+1), width of particle count (6 for default)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
cells_in  input  4*NCELLS  concatenated cell states; cell i = cells_in[4i+3:4i]
snap_req  input  1  capture request, sampled each rising edge
out_data  output  4  state nibble of current cell
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data when high with out_valid
out_last  output  1  high with out_valid on final cell (index NCELLS-1)
busy  output  1  high in SEND and DONE
pop_count  output  CNT_W  particle total of last completed snapshot
count_valid  output  1  one-cycle pulse when pop_count updates
snap_dropped  output  1  one-cycle pulse when snap_req is ignored
frames_sent  output  8  completed snapshots, wraps 255->0

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, snapshot register=0, index=0, accumulator=0. Outputs: out_valid=0, out_last=0, busy=0, pop_count=0, count_valid=0, snap_dropped=0, frames_sent=0. Reset mid-stream aborts the frame; no count_valid; frames_sent is not incremented.
- States: IDLE, SEND, DONE.
- IDLE, snap_req=1 at edge:
  - register <- cells_in, index <- 0, accumulator <- 0, go to SEND.
  - out_valid=1 from the following cycle: 1-cycle capture-to-valid latency.
  - pop_count keeps its old value until DONE.
- SEND:
  - out_data = register nibble[index], combinational from registers.
  - out_last = (index==NCELLS-1).
  - out_data/out_last remain stable while out_valid=1 and out_ready=0.
  - A transfer occurs at an edge with out_valid&&out_ready: accumulator += popcount(out_data), zero-extended to CNT_W, no overflow possible.
  - Non-last transfer: index+1. Last transfer: go to DONE.
  - Back-to-back transfers every cycle are supported when out_ready is held high.
- DONE, exactly one cycle:
  - out_valid=0, count_valid=1, pop_count = accumulator, which includes the last nibble.
  - frames_sent += 1, mod 256.
  - Next state IDLE.
- snap_req while busy (SEND or DONE): no capture, no effect on the frame in progress; snap_dropped=1 the next cycle.
- snap_req in the IDLE cycle immediately after DONE is accepted normally. Minimum period between snapshots is NCELLS+2 cycles.
- cells_in changes after capture do not affect the streamed frame.
- out_valid never deasserts without a transfer, except on reset.
- out_ready is ignored when out_valid=0.
- snap_dropped and count_valid are registered pulses, never high for two consecutive cycles from a single event.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; out_valid never asserts.
- NCELLS=8, cells_in=32'h0000_A5F1, out_ready=1, snap_req pulse:
  - out_valid high 8 consecutive cycles starting one cycle after capture.
  - out_data sequence 1,F,5,A,0,0,0,0; out_last only on 8th.
  - Next cycle count_valid=1, pop_count=9, frames_sent=1.
- Same capture, out_ready toggled 1,0,0,1,... and cells_in changed to all-F after capture -> identical nibble sequence, out_data stable during stalls, pop_count=9.
- snap_req held high throughout a frame:
  - snap_dropped pulses for each cycle of SEND/DONE.
  - A second frame starts from the IDLE cycle after DONE.
  - frames_sent increments 1 then 2.
- rst_n low at the 4th transfer of a frame -> next cycle out_valid=0, busy=0, frames_sent=0, no count_valid.
- 256 complete frames with cells_in=all-F -> pop_count=32 each, frames_sent wraps to 0 after the 256th.
